// File: rtl/cv32e40px_sleep_gate_ctrl.sv
// cv32e40px_sleep_gate_ctrl: debounced core-sleep clock-gate enable with wake settle window.
// Optional gated-cycle counter is enabled by defining SLEEP_GATE_CNT_EN.
module cv32e40px_sleep_gate_ctrl #(
  parameter int ENTRY_CYCLES = 4,
  parameter int EXIT_CYCLES  = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 core_sleep_i,
  input  logic                 sleep_allow_i,
  input  logic                 irq_pending_i,
  input  logic                 debug_req_i,
  input  logic                 cnt_clear_i,
  output logic                 clk_gate_en_o,
  output logic [1:0]           sleep_state_o,
  output logic                 wake_o,
  output logic [CNT_WIDTH-1:0] sleep_cnt_o
);
  typedef enum logic [1:0] {ACTIVE = 2'd0, ENTRY = 2'd1, GATED = 2'd2, EXIT = 2'd3} state_e;
  localparam logic [7:0] ENTRY_T = 8'(ENTRY_CYCLES);
  localparam logic [7:0] EXIT_T  = 8'(EXIT_CYCLES);
  state_e     r_state, w_state_nxt;
  logic [7:0] r_timer, w_timer_nxt;
  logic       r_rearm, w_rearm_nxt, r_gate_en, r_wake;
  logic       w_stay, w_gated_exit;
  // w_stay: conditions that keep the core asleep (no wake, still sleeping, still allowed)
  assign w_stay       = core_sleep_i & sleep_allow_i & ~(irq_pending_i | debug_req_i);
  assign w_gated_exit = (r_state == GATED) & ~w_stay;
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_rearm_nxt = r_rearm;
    unique case (r_state)
      ACTIVE: begin
        if (!core_sleep_i) w_rearm_nxt = 1'b1;
        if (w_stay && r_rearm) begin
          w_state_nxt = ENTRY;
          w_timer_nxt = 8'd1;
        end
      end
      ENTRY: begin
        if (!w_stay) w_state_nxt = ACTIVE;
        else if (r_timer == ENTRY_T) w_state_nxt = GATED;
        else w_timer_nxt = r_timer + 8'd1;
      end
      GATED: begin
        if (!w_stay) begin
          w_state_nxt = EXIT;
          w_timer_nxt = 8'd1;
        end
      end
      EXIT: begin
        if (r_timer == EXIT_T) begin
          w_state_nxt = ACTIVE;
          w_rearm_nxt = 1'b0;
        end else w_timer_nxt = r_timer + 8'd1;
      end
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ACTIVE;
      r_timer   <= 8'd0;
      r_rearm   <= 1'b1;
      r_gate_en <= 1'b1;
      r_wake    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_rearm   <= w_rearm_nxt;
      r_gate_en <= w_state_nxt != GATED;
      r_wake    <= w_gated_exit;
    end
  end
  assign clk_gate_en_o = r_gate_en;
  assign sleep_state_o = r_state;
  assign wake_o        = r_wake;
`ifdef SLEEP_GATE_CNT_EN
  logic [CNT_WIDTH-1:0] r_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clear_i) r_cnt <= '0;
    else if (r_state == GATED && w_stay && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  end
  assign sleep_cnt_o = r_cnt;
`else
  logic w_unused;
  assign w_unused    = cnt_clear_i;
  assign sleep_cnt_o = '0;
`endif
endmodule
